// File: rtl/lib_arbiter_pkg.sv
// lib_arbiter_pkg: FSM state type and default geometry for the group readout arbiter.
package lib_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, SEND, RELEASE} state_t;
    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int DEF_GRP_ROWS = 2;
    localparam int DEF_GRP_COLS = 2;
    localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the slot after last.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [W-1:0] k;
    always_comb begin
        gnt = '0;
        idx = '0;
        k = '0;
        for (int i = 1; i <= N; i++) begin
            k = W'((32'(last) + i) % N);
            if (gnt == '0 && req[k]) begin
                gnt[k] = 1'b1;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/pixel_group_rr_arbiter.sv
// pixel_group_rr_arbiter: two-level round-robin readout, groups first, then pixels inside
// the chosen group, with a per-group burst limit and a valid/ready event output.
module pixel_group_rr_arbiter
    import lib_arbiter_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int GRP_ROWS = DEF_GRP_ROWS,
    parameter int GRP_COLS = DEF_GRP_COLS,
    parameter int MAX_BURST = DEF_MAX_BURST,
    localparam int NGRP = (ROWS / GRP_ROWS) * (COLS / GRP_COLS),
    localparam int X_W = $clog2(COLS),
    localparam int Y_W = $clog2(ROWS),
    localparam int G_W = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [ROWS-1:0][COLS-1:0] req_i,
    output logic [ROWS-1:0][COLS-1:0] gnt_o,
    output logic                      req_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [X_W-1:0]            x_add_o,
    output logic [Y_W-1:0]            y_add_o,
    output logic [G_W-1:0]            grp_o,
    output logic                      grp_release_o,
    output logic                      active_o
);
    localparam int GC = COLS / GRP_COLS;
    localparam int NPIX = GRP_ROWS * GRP_COLS;
    localparam int P_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int B_W = $clog2(MAX_BURST + 1);

    state_t state, nxt;
    logic [NGRP-1:0][NPIX-1:0] grp_pix;
    logic [NGRP-1:0] grp_req, grp_gnt;
    logic [G_W-1:0] grp_idx, last_grp;
    logic [NPIX-1:0] pix_gnt;
    logic [P_W-1:0] pix_idx;
    logic [NGRP-1:0][P_W-1:0] last_pix;
    logic [B_W-1:0] burst_cnt;
    logic accept, burst_done;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        for (genvar p = 0; p < NPIX; p++) begin : g_pix
            assign grp_pix[g][p] = req_i[(g / GC) * GRP_ROWS + p / GRP_COLS][(g % GC) * GRP_COLS + p % GRP_COLS];
        end
        assign grp_req[g] = |grp_pix[g];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign gnt_o[r][c] = accept && y_add_o == Y_W'(r) && x_add_o == X_W'(c);
        end
    end

    rr_arbiter #(.N(NGRP)) u_grp_arb (.req(grp_req), .last(last_grp), .gnt(grp_gnt), .idx(grp_idx));
    rr_arbiter #(.N(NPIX)) u_pix_arb (.req(grp_pix[grp_o]), .last(last_pix[grp_o]), .gnt(pix_gnt), .idx(pix_idx));

    assign req_o = |req_i;
    assign evt_valid_o = state == SEND;
    assign grp_release_o = state == RELEASE;
    assign active_o = state != IDLE;
    assign accept = evt_valid_o && evt_ready_i;
    assign burst_done = 32'(burst_cnt) + 1 == MAX_BURST;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (enable_i && |grp_gnt) ? SCAN : IDLE;
            SCAN:    nxt = (enable_i && |pix_gnt) ? SEND : RELEASE;
            SEND:    nxt = !evt_ready_i ? SEND : (burst_done || !enable_i) ? RELEASE : SCAN;
            default: nxt = IDLE;
        endcase
    end

    // Pointers start at the last index so index 0 wins the first search.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            grp_o <= '0;
            last_grp <= G_W'(NGRP - 1);
            last_pix <= {NGRP{P_W'(NPIX - 1)}};
            burst_cnt <= '0;
            x_add_o <= '0;
            y_add_o <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE)
                burst_cnt <= '0;
            if (accept)
                burst_cnt <= burst_cnt + B_W'(1);
            if (state == IDLE && nxt == SCAN) begin
                grp_o <= grp_idx;
                last_grp <= grp_idx;
            end
            if (state == SCAN && nxt == SEND) begin
                last_pix[grp_o] <= pix_idx;
                x_add_o <= X_W'((32'(grp_o) % GC) * GRP_COLS + 32'(pix_idx) % GRP_COLS);
                y_add_o <= Y_W'((32'(grp_o) / GC) * GRP_ROWS + 32'(pix_idx) / GRP_COLS);
            end
        end
    end
endmodule

// File: tb/tb_pixel_group_rr_arbiter.sv
// tb_pixel_group_rr_arbiter: directed tables, corner sequences and a random run against a
// behavioural model of the two-level round-robin readout.
module tb_pixel_group_rr_arbiter;
    import lib_arbiter_pkg::*;
    localparam int R = 8, C = 8, GR = 2, GCL = 2, NG = 16, NP = 4, MB_A = 4, MB_B = 2;

    logic clk = 0, rst = 1, en = 0, rdy = 0;
    logic [7:0][7:0] req = '0;
    logic [7:0][7:0] a_gnt, b_gnt;
    logic a_reqo, a_valid, a_rel, a_act, b_reqo, b_valid, b_rel, b_act;
    logic [2:0] a_x, a_y, b_x, b_y;
    logic [3:0] a_g, b_g;

    always #5 clk = ~clk;

    pixel_group_rr_arbiter #(.ROWS(R), .COLS(C), .GRP_ROWS(GR), .GRP_COLS(GCL), .MAX_BURST(MB_A)) dut_a (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .req_i(req), .gnt_o(a_gnt), .req_o(a_reqo),
        .evt_valid_o(a_valid), .evt_ready_i(rdy), .x_add_o(a_x), .y_add_o(a_y), .grp_o(a_g),
        .grp_release_o(a_rel), .active_o(a_act));
    pixel_group_rr_arbiter #(.ROWS(R), .COLS(C), .GRP_ROWS(GR), .GRP_COLS(GCL), .MAX_BURST(MB_B)) dut_b (
        .clk_i(clk), .reset_i(rst), .enable_i(en), .req_i(req), .gnt_o(b_gnt), .req_o(b_reqo),
        .evt_valid_o(b_valid), .evt_ready_i(rdy), .x_add_o(b_x), .y_add_o(b_y), .grp_o(b_g),
        .grp_release_o(b_rel), .active_o(b_act));

    int n_chk = 0, n_fail = 0;
    bit drop = 1;
    logic [15:0] qa[$], qb[$];

    state_t m_st = IDLE;
    int m_lg, m_b, m_x, m_y, m_g;
    int m_lp[NG];

    typedef struct {
        logic [63:0] req;
        bit drop;
        int ncyc;
        bit sel;
        int nev;
        logic [0:7][15:0] ev;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic bit pbit(int g, int p);
        return req[(g / (C / GCL)) * GR + p / GCL][(g % (C / GCL)) * GCL + p % GCL];
    endfunction

    function automatic bit greq(int g);
        bit any = 0;
        for (int p = 0; p < NP; p++) any |= pbit(g, p);
        return any;
    endfunction

    task automatic model_step();
        bit found;
        int np;
        if (rst) begin
            m_st = IDLE; m_lg = NG - 1; m_b = 0; m_x = 0; m_y = 0; m_g = 0;
            for (int i = 0; i < NG; i++) m_lp[i] = NP - 1;
        end else begin
            case (m_st)
                IDLE: begin
                    m_b = 0;
                    if (en && req != 0) begin
                        found = 0;
                        for (int i = 1; i <= NG; i++)
                            if (!found && greq((m_lg + i) % NG)) begin found = 1; m_g = (m_lg + i) % NG; end
                        m_lg = m_g;
                        m_st = SCAN;
                    end
                end
                SCAN: begin
                    if (en && greq(m_g)) begin
                        found = 0; np = 0;
                        for (int i = 1; i <= NP; i++)
                            if (!found && pbit(m_g, (m_lp[m_g] + i) % NP)) begin found = 1; np = (m_lp[m_g] + i) % NP; end
                        m_lp[m_g] = np;
                        m_y = (m_g / (C / GCL)) * GR + np / GCL;
                        m_x = (m_g % (C / GCL)) * GCL + np % GCL;
                        m_st = SEND;
                    end else m_st = RELEASE;
                end
                SEND: if (rdy) begin
                    m_b++;
                    m_st = (m_b == MB_A || !en) ? RELEASE : SCAN;
                end
                default: m_st = IDLE;
            endcase
        end
    endtask

    task automatic cycle();
        logic [7:0][7:0] eg;
        #1;
        eg = '0;
        if (m_st == SEND && rdy) eg[m_y][m_x] = 1'b1;
        chk("valid", 64'(a_valid), 64'(m_st == SEND));
        chk("release", 64'(a_rel), 64'(m_st == RELEASE));
        chk("active", 64'(a_act), 64'(m_st != IDLE));
        chk("req_o", 64'(a_reqo), 64'(req != 0));
        chk("gnt", a_gnt, eg);
        if (m_st == SEND) begin
            chk("x", 64'(a_x), 64'(m_x));
            chk("y", 64'(a_y), 64'(m_y));
            chk("grp", 64'(a_g), 64'(m_g));
        end
        if (a_valid && rdy) qa.push_back({4'h0, a_g, 1'b0, a_y, 1'b0, a_x});
        if (b_valid && rdy) qb.push_back({4'h0, b_g, 1'b0, b_y, 1'b0, b_x});
        @(posedge clk);
        #1;
        model_step();
        if (drop) req = req & ~eg;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; rdy = 0; req = '0;
        cycle();
        cycle();
        rst = 0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        logic [15:0] got;
        logic [7:0][7:0] eg;
        vecs[0] = '{req: 64'd1 << 43, drop: 1, ncyc: 10, sel: 0, nev: 1, ev: {16'h0953, 112'd0}};
        vecs[1] = '{req: 64'h0303, drop: 1, ncyc: 12, sel: 0, nev: 4,
                    ev: {16'h0000, 16'h0001, 16'h0010, 16'h0011, 64'd0}};
        vecs[2] = '{req: 64'h0F0F, drop: 0, ncyc: 25, sel: 1, nev: 8,
                    ev: {16'h0000, 16'h0001, 16'h0102, 16'h0103, 16'h0010, 16'h0011, 16'h0112, 16'h0113}};
        vecs[3] = '{req: 64'h0F0F, drop: 0, ncyc: 21, sel: 0, nev: 8,
                    ev: {16'h0000, 16'h0001, 16'h0010, 16'h0011, 16'h0102, 16'h0103, 16'h0112, 16'h0113}};
        vecs[4] = '{req: 64'h8000_0000_0000_0001, drop: 1, ncyc: 10, sel: 0, nev: 2,
                    ev: {16'h0000, 16'h0F77, 96'd0}};

        @(posedge clk);
        @(negedge clk);
        model_step();
        do_reset();
        #1;
        chk("rst_valid", 64'(a_valid), 0);
        chk("rst_rel", 64'(a_rel), 0);
        chk("rst_active", 64'(a_act), 0);
        chk("rst_addr", {a_g, a_y, a_x}, 0);
        chk("rst_gnt", a_gnt, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            req = vecs[v].req; drop = vecs[v].drop; en = 1; rdy = 1;
            repeat (vecs[v].ncyc) cycle();
            chk($sformatf("vec%0d_count", v), vecs[v].sel ? qb.size() : qa.size(), vecs[v].nev);
            for (int i = 0; i < vecs[v].nev; i++) begin
                got = vecs[v].sel ? (i < qb.size() ? qb[i] : 16'hFFFF) : (i < qa.size() ? qa[i] : 16'hFFFF);
                chk($sformatf("vec%0d_ev%0d", v, i), got, vecs[v].ev[i]);
            end
        end

        // ready held low in SEND: event (x=6,y=2) of group 7 waits with no grant
        do_reset();
        drop = 1; req[2][6] = 1; en = 1; rdy = 0;
        cycle(); cycle();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", 64'(a_valid), 1);
            chk("stall_addr", {a_g, a_y, a_x}, {4'd7, 3'd2, 3'd6});
            chk("stall_gnt", a_gnt, 0);
            cycle();
        end
        rdy = 1;
        #1;
        eg = '0; eg[2][6] = 1'b1;
        chk("stall_gnt_rise", a_gnt, eg);
        cycle(); cycle();
        #1;
        chk("stall_release", 64'(a_rel), 1);
        cycle();

        // enable dropped during SEND
        do_reset();
        drop = 1; req[0][0] = 1; req[0][1] = 1; en = 1; rdy = 1;
        cycle(); cycle();
        en = 0;
        #1;
        chk("en_drop_valid", 64'(a_valid), 1);
        cycle();
        #1;
        chk("en_drop_release", 64'(a_rel), 1);
        cycle();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("en_low_active", 64'(a_act), 0);
            chk("en_low_valid", 64'(a_valid), 0);
            cycle();
        end

        // reset during SEND, then pointers restart at pixel 0
        do_reset();
        drop = 0; req[0][0] = 1; req[1][1] = 1; en = 1; rdy = 1;
        repeat (4) cycle();
        rdy = 0;
        #1;
        chk("pre_rst_addr", {a_g, a_y, a_x}, {4'd0, 3'd1, 3'd1});
        rst = 1;
        cycle();
        rst = 0; rdy = 1;
        #1;
        chk("mid_rst_valid", 64'(a_valid), 0);
        chk("mid_rst_flags", {a_rel, a_act}, 0);
        chk("mid_rst_addr", {a_g, a_y, a_x}, 0);
        chk("mid_rst_gnt", a_gnt, 0);
        cycle(); cycle();
        #1;
        chk("post_rst_valid", 64'(a_valid), 1);
        chk("post_rst_addr", {a_g, a_y, a_x}, 0);
        cycle();

        // random traffic against the model
        do_reset();
        drop = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 299) == 0;
            en = $urandom_range(0, 9) != 0;
            rdy = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 2) == 0) req[$urandom_range(0, 7)][$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 99) == 0) req = req | {$urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
